// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: scan/sync bundle between the VGA timing generator and its consumers
// Signals: clk_en (pixel strobe into the generator); pixel_row, pixel_column, hsync, vsync,
// video_on, frame_start, vblank_tick (scan outputs from the generator).
// Modports: master = timing generator, slave = strobe source / colorizers / VGA port.
interface vga_timing_gen_if;
   logic        clk_en;
   logic [11:0] pixel_row;
   logic [11:0] pixel_column;
   logic        hsync;
   logic        vsync;
   logic        video_on;
   logic        frame_start;
   logic        vblank_tick;
   modport master (
      input  clk_en,
      output pixel_row, pixel_column, hsync, vsync, video_on, frame_start, vblank_tick
   );
   modport slave (
      output clk_en,
      input  pixel_row, pixel_column, hsync, vsync, video_on, frame_start, vblank_tick
   );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: display timing generator and scan driver for the Rojobot video path
// Ports: clk (system clock), reset_n (async active-low reset),
//   bus (vga_timing_gen_if.master): clk_en in; pixel_row, pixel_column, hsync, vsync,
//   video_on, frame_start, vblank_tick out. All outputs are registered and lag the
//   internal counters by one clk_en edge.
// Optional: define VGA_TIMING_SYNC_DELAY_EN to pass hsync/vsync/video_on through
//   SYNC_DELAY extra clk_en stages; coordinates and ticks are never delayed.
module vga_timing_gen #(
   parameter logic [11:0] H_VISIBLE  = 12'd1024,
   parameter logic [11:0] H_FRONT    = 12'd24,
   parameter logic [11:0] H_SYNC     = 12'd136,
   parameter logic [11:0] H_BACK     = 12'd160,
   parameter logic [11:0] V_VISIBLE  = 12'd768,
   parameter logic [11:0] V_FRONT    = 12'd3,
   parameter logic [11:0] V_SYNC     = 12'd6,
   parameter logic [11:0] V_BACK     = 12'd29,
   parameter logic        HS_ACTIVE  = 1'b0,
   parameter logic        VS_ACTIVE  = 1'b0,
   parameter int unsigned SYNC_DELAY = 2
) (
   input logic              clk,
   input logic              reset_n,
   vga_timing_gen_if.master bus
);
   localparam logic [11:0] H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam logic [11:0] V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam logic [11:0] H_SS    = H_VISIBLE + H_FRONT;
   localparam logic [11:0] H_SE    = H_SS + H_SYNC;
   localparam logic [11:0] V_SS    = V_VISIBLE + V_FRONT;
   localparam logic [11:0] V_SE    = V_SS + V_SYNC;
`ifdef VGA_TIMING_SYNC_DELAY_EN
   localparam bit          DLY_EN  = 1'b1;
`else
   localparam bit          DLY_EN  = 1'b0;
`endif
   localparam int unsigned DLY     = DLY_EN ? SYNC_DELAY : 0;

   logic [11:0] h_cnt, v_cnt, row_q, col_q;
   logic        hs_q, vs_q, vo_q, fs_q, vt_q;
   logic        h_last, v_last, hs_d, vs_d, vo_d;

   assign h_last = h_cnt == H_TOTAL - 12'd1;
   assign v_last = v_cnt == V_TOTAL - 12'd1;
   assign hs_d   = (h_cnt >= H_SS && h_cnt < H_SE) ? HS_ACTIVE : ~HS_ACTIVE;
   assign vs_d   = (v_cnt >= V_SS && v_cnt < V_SE) ? VS_ACTIVE : ~VS_ACTIVE;
   assign vo_d   = h_cnt < H_VISIBLE && v_cnt < V_VISIBLE;

   // Ticks clear on every clk edge so they stay one clk wide even with a sparse clk_en.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
         row_q <= '0;
         col_q <= '0;
         hs_q  <= ~HS_ACTIVE;
         vs_q  <= ~VS_ACTIVE;
         vo_q  <= 1'b0;
         fs_q  <= 1'b0;
         vt_q  <= 1'b0;
      end else begin
         fs_q <= 1'b0;
         vt_q <= 1'b0;
         if (bus.clk_en) begin
            h_cnt <= h_last ? 12'd0 : h_cnt + 12'd1;
            v_cnt <= !h_last ? v_cnt : v_last ? 12'd0 : v_cnt + 12'd1;
            row_q <= v_cnt;
            col_q <= h_cnt;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            vo_q  <= vo_d;
            fs_q  <= h_cnt == 12'd0 && v_cnt == 12'd0;
            vt_q  <= h_cnt == 12'd0 && v_cnt == V_VISIBLE;
         end
      end
   end

   assign bus.pixel_row    = row_q;
   assign bus.pixel_column = col_q;
   assign bus.frame_start  = fs_q;
   assign bus.vblank_tick  = vt_q;

   generate
      if (DLY == 0) begin : g_direct
         assign bus.hsync    = hs_q;
         assign bus.vsync    = vs_q;
         assign bus.video_on = vo_q;
      end else begin : g_delay
         // Aligns sync and blanking with the downstream colorizer pipeline.
         logic [DLY-1:0] hs_p, vs_p, vo_p;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               hs_p <= {DLY{~HS_ACTIVE}};
               vs_p <= {DLY{~VS_ACTIVE}};
               vo_p <= '0;
            end else if (bus.clk_en) begin
               hs_p[0] <= hs_q;
               vs_p[0] <= vs_q;
               vo_p[0] <= vo_q;
               for (int i = 1; i < int'(DLY); i++) begin
                  hs_p[i] <= hs_p[i-1];
                  vs_p[i] <= vs_p[i-1];
                  vo_p[i] <= vo_p[i-1];
               end
            end
         end
         assign bus.hsync    = hs_p[DLY-1];
         assign bus.vsync    = vs_p[DLY-1];
         assign bus.video_on = vo_p[DLY-1];
      end
   endgenerate
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen
// Small-geometry instance (15x8 total, sync cols 10..12, rows 5..6) for frame-level checks,
// default-geometry instance for 1024x768 line timing.
module tb_vga_timing_gen;
`ifdef VGA_TIMING_SYNC_DELAY_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   hs_lo, vs_lo, vo_n, fs_n, fs_at, vt_n, vt_row, vt_col, seq_err;
   int   hs_first, hs_last, vs_first, hold_err, en_moves, fs_hi, vt_hi, dbl;
   int   pc, pr, pv, prev_fs, prev_vt, prev_hs, prev_vo, found, vo_lo, vo_fall;
   logic en;

   vga_timing_gen_if sb ();
   vga_timing_gen_if db ();

   vga_timing_gen #(
      .H_VISIBLE(12'd8), .H_FRONT(12'd2), .H_SYNC(12'd3), .H_BACK(12'd2),
      .V_VISIBLE(12'd4), .V_FRONT(12'd1), .V_SYNC(12'd2), .V_BACK(12'd1)
   ) dut (.clk(clk), .reset_n(rst_n), .bus(sb));

   vga_timing_gen dut_d (.clk(clk), .reset_n(rst_n), .bus(db));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      sb.clk_en = 1'b1;
      db.clk_en = 1'b0;
      repeat (3) step();
      chk("rst_col", sb.pixel_column, 0);
      chk("rst_row", sb.pixel_row, 0);
      chk("rst_hsync", sb.hsync, 1);
      chk("rst_vsync", sb.vsync, 1);
      chk("rst_video_on", sb.video_on, 0);
      chk("rst_frame_start", sb.frame_start, 0);
      chk("rst_vblank_tick", sb.vblank_tick, 0);
      rst_n = 1'b1;
      step();
      chk("first_col", sb.pixel_column, 0);
      chk("first_row", sb.pixel_row, 0);
      chk("first_video_on", sb.video_on, (D == 0) ? 1 : 0);
      chk("first_frame_start", sb.frame_start, 1);
      step();
      chk("second_col", sb.pixel_column, 1);
      chk("second_frame_start", sb.frame_start, 0);

      // One full frame period with clk_en tied high.
      hs_lo = 0; vs_lo = 0; vo_n = 0; fs_n = 0; fs_at = -1; vt_n = 0; vt_row = -1; vt_col = -1;
      seq_err = 0; hs_first = -1; hs_last = -1; vs_first = -1;
      for (int i = 2; i < 122; i++) begin
         step();
         if (sb.pixel_column != 12'(i % 15) || sb.pixel_row != 12'((i / 15) % 8)) seq_err++;
         if (!sb.hsync) begin
            hs_lo++;
            if (hs_first < 0) hs_first = int'(sb.pixel_column);
            hs_last = int'(sb.pixel_column);
         end
         if (!sb.vsync) begin
            vs_lo++;
            if (vs_first < 0) vs_first = i;
         end
         if (sb.video_on) vo_n++;
         if (sb.frame_start) begin fs_n++; fs_at = i; end
         if (sb.vblank_tick) begin vt_n++; vt_row = int'(sb.pixel_row); vt_col = int'(sb.pixel_column); end
      end
      chk("scan_sequence_errors", seq_err, 0);
      chk("hsync_low_count", hs_lo, 24);
      chk("hsync_first_low_col", hs_first, 10 + D);
      chk("hsync_last_low_col", hs_last, 12 + D);
      chk("vsync_low_count", vs_lo, 30);
      chk("vsync_first_low_index", vs_first, 75 + D);
      chk("video_on_count", vo_n, 32);
      chk("frame_start_count", fs_n, 1);
      chk("frame_period", fs_at, 120);
      chk("vblank_tick_count", vt_n, 1);
      chk("vblank_tick_row", vt_row, 4);
      chk("vblank_tick_col", vt_col, 0);

      // clk_en high one cycle in three.
      hold_err = 0; en_moves = 0; fs_hi = 0; vt_hi = 0; dbl = 0; prev_fs = 0; prev_vt = 0;
      for (int k = 0; k < 390; k++) begin
         en = (k % 3 == 0);
         sb.clk_en = en;
         pc = int'(sb.pixel_column); pr = int'(sb.pixel_row); pv = int'(sb.video_on);
         step();
         if (!en && (int'(sb.pixel_column) != pc || int'(sb.pixel_row) != pr || int'(sb.video_on) != pv)) hold_err++;
         if (en && int'(sb.pixel_column) != pc) en_moves++;
         if (sb.frame_start) fs_hi++;
         if (sb.vblank_tick) vt_hi++;
         if ((sb.frame_start && prev_fs != 0) || (sb.vblank_tick && prev_vt != 0)) dbl++;
         prev_fs = int'(sb.frame_start);
         prev_vt = int'(sb.vblank_tick);
      end
      sb.clk_en = 1'b1;
      chk("sparse_hold_errors", hold_err, 0);
      chk("sparse_enabled_moves", en_moves, 130);
      chk("sparse_frame_start_clks", fs_hi, 1);
      chk("sparse_vblank_tick_clks", vt_hi, 1);
      chk("sparse_tick_wider_than_one", dbl, 0);

      // Reset mid-frame at row 2, col 5.
      found = 0;
      for (int k = 0; k < 200 && found == 0; k++) begin
         step();
         if (sb.pixel_row == 12'd2 && sb.pixel_column == 12'd5) found = 1;
      end
      chk("find_row2_col5", found, 1);
      chk("pre_reset_video_on", sb.video_on, 1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_col", sb.pixel_column, 0);
      chk("async_rst_row", sb.pixel_row, 0);
      chk("async_rst_hsync", sb.hsync, 1);
      chk("async_rst_video_on", sb.video_on, 0);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("restart_col", sb.pixel_column, 0);
      chk("restart_row", sb.pixel_row, 0);
      chk("restart_frame_start", sb.frame_start, 1);
      chk("restart_video_on", sb.video_on, (D == 0) ? 1 : 0);

      // Default 1024x768 geometry: one full line.
      db.clk_en = 1'b1;
      hs_lo = 0; hs_first = -1; hs_last = -1; vo_lo = 0; vo_fall = -1; prev_hs = 1; prev_vo = 0;
      for (int i = 0; i <= 1344; i++) begin
         step();
         if (i == 0) begin
            chk("line_first_col", db.pixel_column, 0);
            chk("line_first_row", db.pixel_row, 0);
         end
         if (i == 1343) chk("line_last_col", db.pixel_column, 1343);
         if (i == 1344) begin
            chk("line_wrap_col", db.pixel_column, 0);
            chk("line_wrap_row", db.pixel_row, 1);
         end
         if (i < 1344) begin
            if (!db.hsync) begin
               hs_lo++;
               if (prev_hs != 0) hs_first = int'(db.pixel_column);
            end else if (prev_hs == 0) hs_last = int'(db.pixel_column) - 1;
            if (!db.video_on) begin
               vo_lo++;
               if (prev_vo != 0) vo_fall = int'(db.pixel_column);
            end
            prev_hs = int'(db.hsync);
            prev_vo = int'(db.video_on);
         end
      end
      chk("line_hsync_low_count", hs_lo, 136);
      chk("line_hsync_fall_col", hs_first, 1048 + D);
      chk("line_hsync_last_low_col", hs_last, 1183 + D);
      chk("line_video_off_count", vo_lo, 320);
      chk("line_video_off_col", vo_fall, 1024 + D);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
